// File: rtl/minimips_defs.sv
// rtl/minimips_defs.sv - shared MiniMIPS opcode, ALU and multicycle state encodings
// Purpose: constants shared by main control, ALU control and the multicycle sequencer.
// Ports: none (package).
package minimips_defs;

  // 4-bit opcode map
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_BNE   = 4'b0110;
  localparam logic [3:0] OP_XORI  = 4'b0111;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;

  // ALUop encoding
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_IMM   = 2'b11;

  // ALUSrcB encoding
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  // PCSource encoding (10/11 reserved)
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_BRANCH   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_WB_R     = 4'd9,
    S_WB_I     = 4'd10,
    S_WB_MEM   = 4'd11,
    S_ILLEGAL  = 4'd12
  } state_t;

  // State that follows DECODE for a given opcode
  function automatic state_t decode_target(input logic [3:0] op);
    state_t nxt;
    case (op)
      OP_RTYPE:                                 nxt = S_EXEC_R;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: nxt = S_EXEC_I;
      OP_BEQ, OP_BNE:                           nxt = S_BRANCH;
      OP_LW, OP_SW:                             nxt = S_MEM_ADDR;
      default:                                  nxt = S_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational control-output decode for the multicycle sequencer
// Purpose: maps current state (plus opcode for branch polarity and mem_ready for the
//          handshake-qualified strobes) onto every datapath enable and mux select.
// Ports: state, opcode, mem_ready in; all MiniMIPS control outputs out.
module mc_output_decode
  import minimips_defs::*;
(
  input  logic [3:0] state,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op
);

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    ALUop         = ALU_ADD;
    PCSource      = PCSRC_ALU;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_ONE;
        // IR load and PC+1 only commit once memory returns the word
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_BROFF;   // precompute branch target into ALUOut
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUop   = ALU_IMM;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = ALU_SUB;
        PCSource      = PCSRC_ALUOUT;
        PCWriteCond   = (opcode == OP_BEQ);
        PCWriteCondNe = (opcode == OP_BNE);
        instr_done    = 1'b1;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEM_WR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = mem_ready;
      end
      S_WB_R: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_WB_MEM: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - MiniMIPS multicycle sequencer with memory-ready stalls
// Purpose: steps each instruction through fetch/decode/execute/memory/writeback.
// Ports: clk, reset (sync, active-high), opcode[3:0], mem_ready in;
//        PC/memory/register/ALU controls, instr_done, illegal_op, state[3:0] out.
module multicycle_control
  import minimips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNe,
  output logic       IorD,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_IDLE;
    end else begin
      case (cur)
        S_IDLE:     cur <= S_FETCH;
        S_FETCH:    if (mem_ready) cur <= S_DECODE;
        S_DECODE:   cur <= decode_target(opcode);
        S_EXEC_R:   cur <= S_WB_R;
        S_EXEC_I:   cur <= S_WB_I;
        // only lw/sw reach MEM_ADDR, so anything other than lw is a store
        S_MEM_ADDR: cur <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) cur <= S_WB_MEM;
        S_MEM_WR:   if (mem_ready) cur <= S_FETCH;
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_ILLEGAL: cur <= S_FETCH;
        default:    cur <= S_IDLE;
      endcase
    end
  end

  assign state = cur;

  mc_output_decode u_decode (
    .state        (cur),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .PCWrite      (PCWrite),
    .PCWriteCond  (PCWriteCond),
    .PCWriteCondNe(PCWriteCondNe),
    .IorD         (IorD),
    .IRWrite      (IRWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .RegDst       (RegDst),
    .RegWrite     (RegWrite),
    .MemtoReg     (MemtoReg),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUop        (ALUop),
    .PCSource     (PCSource),
    .instr_done   (instr_done),
    .illegal_op   (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
  import minimips_defs::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, PCWriteCond, PCWriteCondNe, IorD, IRWrite, MemRead, MemWrite;
  logic       RegDst, RegWrite, MemtoReg, ALUSrcA, instr_done, illegal_op;
  logic [1:0] ALUSrcB, ALUop, PCSource;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe),
    .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Expectation for the current cycle, written only by the driver
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_state = 4'd0;
  logic [18:0] exp_vec   = 19'd0;
  logic        pin_en    = 1'b0;
  logic [18:0] pin_vec   = 19'd0;
  int          exp_cpi   = 0;

  // Counters, written only by the compare process
  int          n_vec  = 0;
  int          n_miss = 0;
  int          cyc    = 0;
  logic [3:0]  prev_state = 4'd0;

  // Control word order:
  // PCWrite PCWriteCond PCWriteCondNe | IorD IRWrite MemRead MemWrite |
  // RegDst RegWrite MemtoReg ALUSrcA | ALUSrcB | ALUop | PCSource | instr_done | illegal_op
  function automatic logic [18:0] model_ctrl(input logic [3:0] ph, input logic [3:0] op,
                                             input logic mr);
    logic pcw, pcc, pcn, iord, irw, mrd, mwr, rd, rw, m2r, asa, done, ill;
    logic [1:0] sb, aop, ps;
    {pcw, pcc, pcn, iord, irw, mrd, mwr, rd, rw, m2r, asa, done, ill} = '0;
    sb = 2'b00; aop = 2'b00; ps = 2'b00;
    if (ph == S_FETCH)    begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
    if (ph == S_DECODE)   sb = 2'b11;
    if (ph == S_EXEC_R)   begin asa = 1; aop = 2'b10; end
    if (ph == S_EXEC_I)   begin asa = 1; sb = 2'b10; aop = 2'b11; end
    if (ph == S_WB_R)     begin rd = 1; rw = 1; done = 1; end
    if (ph == S_WB_I)     begin rw = 1; done = 1; end
    if (ph == S_BRANCH)   begin
      asa = 1; aop = 2'b01; ps = 2'b01; done = 1;
      pcc = (op == 4'b0101); pcn = (op == 4'b0110);
    end
    if (ph == S_MEM_ADDR) begin asa = 1; sb = 2'b10; end
    if (ph == S_MEM_RD)   begin iord = 1; mrd = 1; end
    if (ph == S_WB_MEM)   begin m2r = 1; rw = 1; done = 1; end
    if (ph == S_MEM_WR)   begin iord = 1; mwr = 1; done = mr; end
    if (ph == S_ILLEGAL)  ill = 1;
    return {pcw, pcc, pcn, iord, irw, mrd, mwr, rd, rw, m2r, asa, sb, aop, ps, done, ill};
  endfunction

  // Single compare process: every checked cycle, away from the active edge
  always @(negedge clk) begin
    logic [18:0] act;
    if (exp_valid) begin
      act = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, IRWrite, MemRead, MemWrite,
             RegDst, RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUop, PCSource,
             instr_done, illegal_op};
      n_vec = n_vec + 1;
      if (state !== exp_state) begin
        n_miss = n_miss + 1;
        $display("FAIL state @%0t: got %0d want %0d", $time, state, exp_state);
      end
      n_vec = n_vec + 1;
      if (act !== exp_vec) begin
        n_miss = n_miss + 1;
        $display("FAIL ctrl @%0t (state %0d): got %b want %b", $time, exp_state, act, exp_vec);
      end
      if (pin_en) begin
        n_vec = n_vec + 1;
        if (act !== pin_vec) begin
          n_miss = n_miss + 1;
          $display("FAIL pinned ctrl @%0t: got %b want %b", $time, act, pin_vec);
        end
      end
      if (state == S_FETCH && prev_state != S_FETCH) cyc = 1;
      else cyc = cyc + 1;
      prev_state = state;
      if (exp_cpi != 0) begin
        n_vec = n_vec + 1;
        if (cyc != exp_cpi) begin
          n_miss = n_miss + 1;
          $display("FAIL cycles-per-instr @%0t: got %0d want %0d", $time, cyc, exp_cpi);
        end
      end
    end
  end

  // One cycle: drive inputs just after the edge, publish the expectation, advance
  task automatic step(input logic [3:0] ph, input logic mr, input logic [3:0] op,
                      input logic rst, input int cpi, input logic pen, input logic [18:0] pv);
    mem_ready = mr;
    opcode    = op;
    reset     = rst;
    exp_state = ph;
    exp_vec   = model_ctrl(ph, op, mr);
    exp_cpi   = cpi;
    pin_en    = pen;
    pin_vec   = pv;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rnd_op();
    return 4'($urandom_range(0, 15));
  endfunction

  // Whole instruction: fs fetch stalls, ms memory stalls; last state pinned with a literal
  task automatic run_instr(input logic [3:0] op, input int fs, input int ms, input int cpi,
                           input logic fpen, input logic [18:0] fpin, input logic [18:0] lpin);
    for (int i = 0; i < fs; i++) step(S_FETCH, 1'b0, rnd_op(), 1'b0, 0, 1'b0, 19'd0);
    step(S_FETCH, 1'b1, rnd_op(), 1'b0, 0, fpen, fpin);
    step(S_DECODE, rnd_bit(), op, 1'b0, 0, 1'b0, 19'd0);
    case (op)
      4'b0000: begin
        step(S_EXEC_R, rnd_bit(), op, 1'b0, 0, 1'b0, 19'd0);
        step(S_WB_R, rnd_bit(), op, 1'b0, cpi, 1'b1, lpin);
      end
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0111: begin
        step(S_EXEC_I, rnd_bit(), op, 1'b0, 0, 1'b0, 19'd0);
        step(S_WB_I, rnd_bit(), op, 1'b0, cpi, 1'b1, lpin);
      end
      4'b0101, 4'b0110: step(S_BRANCH, rnd_bit(), op, 1'b0, cpi, 1'b1, lpin);
      4'b1000: begin
        step(S_MEM_ADDR, rnd_bit(), op, 1'b0, 0, 1'b0, 19'd0);
        for (int i = 0; i < ms; i++) step(S_MEM_RD, 1'b0, op, 1'b0, 0, 1'b0, 19'd0);
        step(S_MEM_RD, 1'b1, op, 1'b0, 0, 1'b0, 19'd0);
        step(S_WB_MEM, rnd_bit(), op, 1'b0, cpi, 1'b1, lpin);
      end
      4'b1001: begin
        step(S_MEM_ADDR, rnd_bit(), op, 1'b0, 0, 1'b0, 19'd0);
        for (int i = 0; i < ms; i++) step(S_MEM_WR, 1'b0, op, 1'b0, 0, 1'b0, 19'd0);
        step(S_MEM_WR, 1'b1, op, 1'b0, cpi, 1'b1, lpin);
      end
      default: step(S_ILLEGAL, rnd_bit(), op, 1'b0, cpi, 1'b1, lpin);
    endcase
  endtask

  localparam logic [18:0] PIN_FETCH  = 19'b100_0110_0000_01_00_00_0_0;
  localparam logic [18:0] PIN_WB_R   = 19'b000_0000_1100_00_00_00_1_0;
  localparam logic [18:0] PIN_WB_I   = 19'b000_0000_0100_00_00_00_1_0;
  localparam logic [18:0] PIN_BEQ    = 19'b010_0000_0001_00_01_01_1_0;
  localparam logic [18:0] PIN_BNE    = 19'b001_0000_0001_00_01_01_1_0;
  localparam logic [18:0] PIN_WB_MEM = 19'b000_0000_0110_00_00_00_1_0;
  localparam logic [18:0] PIN_SW     = 19'b000_1001_0000_00_00_00_1_0;
  localparam logic [18:0] PIN_ILL    = 19'b000_0000_0000_00_00_00_0_1;
  localparam logic [18:0] PIN_ZERO   = 19'b0;

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    step(S_IDLE, 1'b1, 4'b0000, 1'b0, 0, 1'b1, PIN_ZERO);
    run_instr(4'b0000, 0, 0, 4, 1'b1, PIN_FETCH, PIN_WB_R);
    run_instr(4'b0011, 2, 0, 6, 1'b0, PIN_ZERO, PIN_WB_I);
    run_instr(4'b1000, 0, 3, 8, 1'b1, PIN_FETCH, PIN_WB_MEM);
    run_instr(4'b0110, 0, 0, 3, 1'b0, PIN_ZERO, PIN_BNE);
    run_instr(4'b0101, 0, 0, 3, 1'b0, PIN_ZERO, PIN_BEQ);
    run_instr(4'b1100, 0, 0, 3, 1'b0, PIN_ZERO, PIN_ILL);
    run_instr(4'b1001, 0, 1, 5, 1'b0, PIN_ZERO, PIN_SW);
    run_instr(4'b1000, 0, 0, 5, 1'b0, PIN_ZERO, PIN_WB_MEM);
    run_instr(4'b0111, 0, 0, 4, 1'b0, PIN_ZERO, PIN_WB_I);
    run_instr(4'b1111, 1, 0, 4, 1'b0, PIN_ZERO, PIN_ILL);
    // sw stalled in MEM_WR, reset lands mid-stall
    step(S_FETCH, 1'b1, 4'b0000, 1'b0, 0, 1'b0, PIN_ZERO);
    step(S_DECODE, 1'b1, 4'b1001, 1'b0, 0, 1'b0, PIN_ZERO);
    step(S_MEM_ADDR, 1'b1, 4'b1001, 1'b0, 0, 1'b0, PIN_ZERO);
    step(S_MEM_WR, 1'b0, 4'b1001, 1'b0, 0, 1'b0, PIN_ZERO);
    step(S_MEM_WR, 1'b0, 4'b1001, 1'b1, 0, 1'b0, PIN_ZERO);
    step(S_IDLE, 1'b1, 4'b1001, 1'b0, 0, 1'b1, PIN_ZERO);
    run_instr(4'b0000, 0, 0, 4, 1'b1, PIN_FETCH, PIN_WB_R);
    exp_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
